// File: rtl/debug_fmt_pkg.sv
// Shared formatting helpers for the hex telemetry reporter: ASCII framing bytes,
// the FSM state type, byte-index sizing and nibble-to-ASCII conversion.
package debug_fmt_pkg;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rpt_state_e;

  // A message is 'R', '=', the hex digits, CR and LF.
  function automatic int idx_width(input int nibbles);
    return $clog2(nibbles + 4);
  endfunction

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/hex_digit_mux.sv
// Picks one hex digit (0 = most significant) out of the frozen report value
// and returns its uppercase ASCII character.
module hex_digit_mux
  import debug_fmt_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = idx_width(WIDTH / 4)
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [IDX_W-1:0] digit_sel_i,
  output logic [7:0]       ascii_o
);

  localparam int NIBBLES = WIDTH / 4;

  logic [3:0] nib;

  always_comb begin
    nib = '0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (digit_sel_i == IDX_W'(k)) begin
        nib = value_i[4*(NIBBLES-1-k) +: 4];
      end
    end
  end

  assign ascii_o = nibble_to_ascii(nib);

endmodule

// File: rtl/debug_hex_reporter.sv
// Snapshots din on trigger and streams "R=<hex>\r\n" over a valid/ready byte port.
//   state   | meaning
//   ST_IDLE | no message on the wire, waiting for trigger
//   ST_SEND | presenting bytes of the frozen shadow value
module debug_hex_reporter
  import debug_fmt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             trigger,
  output logic [7:0]       tx_byte,
  output logic             tx_byte_valid,
  input  logic             usb_uart_tx_ready,
  output logic             busy,
  output logic [7:0]       overrun_count
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(NIBBLES + 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES + 3);

  rpt_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic [7:0]       ovr_q, ovr_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;

  logic             xfer;
  logic             last_xfer;
  logic             ovr_inc;
  logic [IDX_W-1:0] digit_sel;
  logic [7:0]       digit_ascii;

  assign xfer      = valid_q && usb_uart_tx_ready;
  assign last_xfer = xfer && (idx_q == IDX_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      shadow_q   <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      ovr_q      <= 8'h00;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      ovr_q      <= ovr_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shadow_d   = shadow_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    valid_d    = valid_q;
    ovr_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          shadow_d = din;
          idx_d    = '0;
          state_d  = ST_SEND;
          valid_d  = 1'b1;
        end
      end
      ST_SEND: begin
        if (last_xfer) begin
          idx_d = '0;
          // A fresh trigger beats the pending value; that pending report is lost.
          if (trigger) begin
            shadow_d = din;
            pend_d   = 1'b0;
            ovr_inc  = pend_q;
          end else if (pend_q) begin
            shadow_d = pend_val_q;
            pend_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          if (xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (trigger) begin
            ovr_inc    = pend_q;
            pend_d     = 1'b1;
            pend_val_d = din;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    ovr_d = ovr_q;
    if (ovr_inc && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'h01;
    end
  end

  // The next byte is derived from the next index/shadow, so a stalled byte
  // re-evaluates to the same value and holds steady without extra muxing.
  assign digit_sel = idx_d - IDX_W'(2);

  hex_digit_mux #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_digit (
    .value_i     (shadow_d),
    .digit_sel_i (digit_sel),
    .ascii_o     (digit_ascii)
  );

  always_comb begin
    byte_d = 8'h00;
    if (valid_d) begin
      if (idx_d == '0) begin
        byte_d = ASCII_R;
      end else if (idx_d == IDX_W'(1)) begin
        byte_d = ASCII_EQ;
      end else if (idx_d == IDX_CR) begin
        byte_d = ASCII_CR;
      end else if (idx_d == IDX_LAST) begin
        byte_d = ASCII_LF;
      end else begin
        byte_d = digit_ascii;
      end
    end
  end

  assign tx_byte       = byte_q;
  assign tx_byte_valid = valid_q;
  assign overrun_count = ovr_q;
  assign busy          = (state_q == ST_SEND) || pend_q;

endmodule

// File: doc/debug_hex_reporter.md
Name: debug_hex_reporter

Overview:
- Downstream consumer of the reset-timer debug signals and upstream byte source for the USB UART transmitter.
- On each trigger pulse it snapshots a WIDTH-bit value (e.g. reset counter) and streams it to the UART as an ASCII line "R=<hex>\r\n" over a valid/ready byte handshake.
- Gives human-readable reset/timer telemetry on the USB serial port without a logic analyser.

Parameters:
- WIDTH, 8, bit width of din; multiple of 4, range 4..32.
- NIBBLES, WIDTH/4, number of hex digits emitted (derived, not overridden).

Ports:
- clk  input  1  system clock (48 MHz)
- reset  input  1  asynchronous, active-high reset
- din  input  WIDTH  value to report; sampled only on trigger
- trigger  input  1  single-cycle request to report din
- tx_byte  output  8  ASCII byte to UART
- tx_byte_valid  output  1  tx_byte holds a valid byte
- usb_uart_tx_ready  input  1  UART accepts byte this cycle when valid and ready are both high
- busy  output  1  message in progress or pending
- overrun_count  output  8  saturating count of dropped reports

Behaviour:
- Reset (async assert, sync release): tx_byte_valid=0, tx_byte=8'h00, busy=0, overrun_count=0, pending cleared, FSM=IDLE.
- Reset mid-message aborts immediately; no partial completion after release.
- Message format: 'R'(0x52), '='(0x3D), NIBBLES hex digits MSB first, uppercase '0'-'9'/'A'-'F', CR(0x0D), LF(0x0A). Length is NIBBLES+4 bytes.
- Handshake:
  - A transfer occurs on a cycle with tx_byte_valid && usb_uart_tx_ready.
  - tx_byte and tx_byte_valid are registered and never combinationally dependent on ready.
  - While valid and not ready, tx_byte stays stable.
  - After a transfer, the next byte of the same message is presented the following cycle with valid held high, so there is no bubble.
- FSM:
  - IDLE: trigger=1 captures din into shadow register; next cycle SEND with tx_byte='R', valid=1 (latency 1 cycle).
  - SEND: byte index 0..NIBBLES+3 advances on each transfer.
  - On the final (LF) transfer: if trigger=1 or pending=1, load the new value and present 'R' next cycle. Otherwise go to IDLE with valid=0 next cycle.
- Trigger while SEND (including the final-byte cycle):
  - Value precedence: trigger's din wins over pending value (newest data).
  - If pending already set, the old pending value is discarded and overrun_count increments.
  - Else pending=1 and pending_value=din.
  - On the final-byte cycle, trigger with pending=1 also counts one overrun.
- overrun_count saturates at 8'hFF, with no wrap. It is cleared only by reset.
- busy = (FSM==SEND) || pending.
- Shadow value is frozen for the whole message; din changes mid-message are ignored.
- trigger held high for several cycles acts as repeated triggers; each cycle counts.

Decomposition:
- Package debug_fmt_pkg holds:
  - ASCII constants: ASCII_R, ASCII_EQ, ASCII_CR, ASCII_LF.
  - Byte-index width localparam helper.
  - Function nibble_to_ascii(4-bit) returning 8-bit.
- Optional sub-module hex_digit_mux: selects nibble by index from the shadow register and converts it to ASCII. It keeps the FSM file focused on handshake/pending logic.
- Everything else lives in debug_hex_reporter.

Test Plan:
- WIDTH=8, din=8'hA5, trigger one cycle, ready always 1 -> bytes 52,3D,41,35,0D,0A on six consecutive cycles starting 1 cycle after trigger; then valid=0, busy=0.
- din=8'h0F, ready toggling 1/0 every cycle -> same six bytes 52,3D,30,46,0D,0A in order; tx_byte stable while valid&&!ready; no byte duplicated or skipped.
- Trigger din=8'h01, then during byte 2 trigger din=8'h02, then during byte 4 trigger din=8'h03 -> message "R=01\r\n" then "R=03\r\n" back-to-back with no gap; overrun_count=1.
- Trigger din=8'h11 exactly on the LF-transfer cycle of a running message (pending clear) -> 'R' presented next cycle, message "R=11\r\n", overrun_count=0.
- Assert reset during byte 3 with ready=0 -> tx_byte_valid=0 in the same cycle (async); after release, busy=0, no further bytes until a new trigger.
- 300 triggers while ready=0 held -> overrun_count saturates at 8'hFF; busy=1 throughout.
